// File: rtl/fsm_universal_dwell.sv
// fsm_universal_dwell: run-time programmable sequencing kernel.
// Each state's successor comes from a packed target bus. The kernel also
// supports an advance enable, a per-state minimum dwell, forced jumps,
// illegal-target detection, and previous-state / entry reporting.
module fsm_universal_dwell #(
  parameter  int N_STATES  = 8,
  parameter  int DWELL_W   = 8,
  parameter  int RST_STATE = 0,
  localparam int SW        = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_STATES*SW-1:0]      tx,
  input  logic [N_STATES*DWELL_W-1:0] dwell,
  input  logic                        force_valid,
  input  logic [SW-1:0]               force_state,
  output logic [N_STATES-1:0]         st,
  output logic [SW-1:0]               state,
  output logic [SW-1:0]               prev_state,
  output logic                        entered,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned NS = N_STATES;

  logic [SW-1:0]      cstate_q, cstate_d;
  logic [SW-1:0]      prev_q, prev_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               entered_q, entered_d;
  logic               err_q, err_d;

  logic [SW-1:0] tgt;
  logic          take;
  int unsigned   a_idx, a_safe, t_idx, f_idx;

  // Next-state decision: reset recovery, then force, then normal advance.
  always_comb begin
    cstate_d  = cstate_q;
    prev_d    = prev_q;
    entered_d = 1'b0;
    err_d     = 1'b0;
    cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    take      = 1'b0;
    tgt       = cstate_q;
    a_idx     = 32'(cstate_q);
    a_safe    = (a_idx < NS) ? a_idx : 0;
    t_idx     = 32'(tx[a_safe*SW +: SW]);
    f_idx     = 32'(force_state);

    if (a_idx >= NS) begin
      // Unreachable encoding: recover to the reset state and flag it.
      cstate_d  = SW'(RST_STATE);
      prev_d    = cstate_q;
      entered_d = 1'b1;
      err_d     = 1'b1;
      cnt_d     = '0;
    end else if (force_valid) begin
      if (f_idx < NS) begin
        take = 1'b1;
        tgt  = force_state;
      end else begin
        err_d = 1'b1;
      end
    end else if (en && (cnt_q == '0)) begin
      if (t_idx >= NS) begin
        err_d = 1'b1;
      end else if (t_idx != a_idx) begin
        take = 1'b1;
        tgt  = SW'(t_idx);
      end
    end

    if (take) begin
      cstate_d  = tgt;
      prev_d    = cstate_q;
      entered_d = 1'b1;
      cnt_d     = dwell[32'(tgt)*DWELL_W +: DWELL_W];
    end
  end

  // State, history, dwell counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cstate_q  <= SW'(RST_STATE);
      prev_q    <= SW'(RST_STATE);
      cnt_q     <= '0;
      entered_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cstate_q  <= cstate_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      entered_q <= entered_d;
      err_q     <= err_d;
    end
  end

  // One-hot decode of the current state.
  always_comb begin
    st = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      st[s] = (32'(cstate_q) == s);
    end
  end

  assign state      = cstate_q;
  assign prev_state = prev_q;
  assign entered    = entered_q;
  assign busy       = (cnt_q != '0);
  assign err        = err_q;

endmodule

// File: tb/tb_fsm_universal_dwell.sv
// Testbench for fsm_universal_dwell (5 states, so targets 5..7 are illegal).
module tb_fsm_universal_dwell;

  localparam int N  = 5;
  localparam int SW = 3;
  localparam int DW = 4;
  localparam int RS = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N*SW-1:0] tx;
  logic [N*DW-1:0] dwell;
  logic            force_valid;
  logic [SW-1:0]   force_state;
  logic [N-1:0]    st;
  logic [SW-1:0]   state;
  logic [SW-1:0]   prev_state;
  logic            entered;
  logic            busy;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Reference model: per-state targets/dwells and the architectural state.
  int txa[N];
  int dwa[N];
  int m_state, m_prev, m_cnt;
  bit m_ent, m_err;

  fsm_universal_dwell #(.N_STATES(N), .DWELL_W(DW), .RST_STATE(RS)) dut (
    .clk(clk), .rst(rst), .en(en), .tx(tx), .dwell(dwell),
    .force_valid(force_valid), .force_state(force_state),
    .st(st), .state(state), .prev_state(prev_state),
    .entered(entered), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pack();
    for (int s = 0; s < N; s++) begin
      tx[s*SW +: SW]    = SW'(txa[s]);
      dwell[s*DW +: DW] = DW'(dwa[s]);
    end
  endtask

  // One clock: apply inputs, advance the model by the rules, compare outputs.
  task automatic step();
    int  nxt;
    bit  e;
    pack();
    @(posedge clk);
    if (rst) begin
      m_state = RS; m_prev = RS; m_cnt = 0; m_ent = 0; m_err = 0;
    end else begin
      nxt = -1;
      e   = 0;
      if (force_valid) begin
        if (int'(force_state) < N) nxt = int'(force_state);
        else e = 1;
      end else if (en && m_cnt == 0) begin
        if (txa[m_state] >= N) e = 1;
        else if (txa[m_state] != m_state) nxt = txa[m_state];
      end
      if (nxt >= 0) begin
        m_prev  = m_state;
        m_state = nxt;
        m_cnt   = dwa[nxt];
        m_ent   = 1;
      end else begin
        m_ent = 0;
        if (m_cnt > 0) m_cnt--;
      end
      m_err = e;
    end
    #1;
    chk("st",         32'(st),         32'(1) << m_state);
    chk("state",      32'(state),      32'(m_state));
    chk("prev_state", 32'(prev_state), 32'(m_prev));
    chk("entered",    32'(entered),    32'(m_ent));
    chk("busy",       32'(busy),       32'(m_cnt != 0));
    chk("err",        32'(err),        32'(m_err));
  endtask

  task automatic go(input int s);
    force_valid = 1'b1;
    force_state = SW'(s);
    step();
    force_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; force_valid = 1'b0; force_state = '0;
    for (int s = 0; s < N; s++) begin txa[s] = (s + 1) % N; dwa[s] = 0; end
    m_state = RS; m_prev = RS; m_cnt = 0; m_ent = 0; m_err = 0;

    // Reset state.
    step(); step();
    rst = 1'b0;

    // Ring walk with zero dwell: one step per clock.
    en = 1'b1;
    for (int i = 0; i < 2 * N; i++) step();

    // Dwell of 3 in state 2: 1 -> 2 (held 4 cycles) -> 4.
    dwa[2] = 3; txa[1] = 2; txa[2] = 4;
    go(1);
    for (int i = 0; i < 7; i++) step();

    // Enable low freezes the decision.
    txa[0] = 4;
    go(0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    en = 1'b1;
    step(); step();

    // Force mid-dwell, then force to the current state (re-entry).
    dwa[2] = 3; dwa[4] = 2;
    go(2); step();
    go(4);
    step();
    go(4);
    step(); step(); step();

    // Illegal normal target and illegal force target.
    txa[1] = 7;
    go(1);
    step(); step();
    go(5);
    go(7);
    step();

    // Reset in the middle of a dwell.
    dwa[3] = 5;
    go(3);
    step();
    rst = 1'b1; step();
    rst = 1'b0; step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      en          = ($urandom_range(0, 3) != 0);
      force_valid = ($urandom_range(0, 9) == 0);
      force_state = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        for (int s = 0; s < N; s++) begin
          txa[s] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, N - 1))
                                              : int'($urandom_range(N, 7));
          dwa[s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 2));
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
